// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the R/I-type CPU datapath: fetch, decode, execute,
// memory and write-back phases on a single clock, with run/step control and halt.
module multicycle_ctrl #(
    parameter int MEM_TMO = 15,
    parameter int TMO_W   = 4,
    parameter int ICNT_W  = 16
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              run,
    input  logic              step,
    input  logic [5:0]        opa,
    input  logic [5:0]        funca,
    input  logic              mem_rdy,
    output logic              pc_we,
    output logic              ir_we,
    output logic              reg_we,
    output logic              mem_we,
    output logic              mem_re,
    output logic [2:0]        aop,
    output logic              rdts,
    output logic              is,
    output logic              rims,
    output logic              ams,
    output logic [2:0]        state,
    output logic              halted,
    output logic [1:0]        err,
    output logic [ICNT_W-1:0] icnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6,
        S_BAD  = 3'd7
    } state_t;

    localparam logic [2:0] AOP_AND  = 3'b000;
    localparam logic [2:0] AOP_OR   = 3'b001;
    localparam logic [2:0] AOP_XOR  = 3'b010;
    localparam logic [2:0] AOP_NOR  = 3'b011;
    localparam logic [2:0] AOP_ADD  = 3'b100;
    localparam logic [2:0] AOP_SUB  = 3'b101;
    localparam logic [2:0] AOP_SLTU = 3'b110;
    localparam logic [2:0] AOP_SLLV = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ILL  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TMO);

    // Datapath selects captured in ID and held for the rest of the instruction.
    typedef struct packed {
        logic [2:0] aop;
        logic       rdts;
        logic       is;
        logic       rims;
        logic       ams;
        logic       lw;
        logic       sw;
    } sel_t;

    typedef struct packed {
        logic legal;
        logic halt;
        sel_t sel;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d       = '0;
        d.legal = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    6'b100100: d.sel.aop = AOP_AND;
                    6'b100101: d.sel.aop = AOP_OR;
                    6'b100110: d.sel.aop = AOP_XOR;
                    6'b100111: d.sel.aop = AOP_NOR;
                    6'b100000: d.sel.aop = AOP_ADD;
                    6'b100010: d.sel.aop = AOP_SUB;
                    6'b101011: d.sel.aop = AOP_SLTU;
                    6'b000100: d.sel.aop = AOP_SLLV;
                    default:   d.legal   = 1'b0;
                endcase
            end
            OP_ADDI: begin
                d.sel.aop  = AOP_ADD;
                d.sel.rdts = 1'b1;
                d.sel.rims = 1'b1;
                d.sel.is   = 1'b1;
            end
            OP_ANDI: begin
                d.sel.aop  = AOP_AND;
                d.sel.rdts = 1'b1;
                d.sel.rims = 1'b1;
            end
            OP_ORI: begin
                d.sel.aop  = AOP_OR;
                d.sel.rdts = 1'b1;
                d.sel.rims = 1'b1;
            end
            OP_XORI: begin
                d.sel.aop  = AOP_XOR;
                d.sel.rdts = 1'b1;
                d.sel.rims = 1'b1;
            end
            OP_SLTIU: begin
                d.sel.aop  = AOP_SLTU;
                d.sel.rdts = 1'b1;
                d.sel.rims = 1'b1;
                d.sel.is   = 1'b1;
            end
            OP_LW: begin
                d.sel.aop  = AOP_ADD;
                d.sel.rdts = 1'b1;
                d.sel.rims = 1'b1;
                d.sel.is   = 1'b1;
                d.sel.ams  = 1'b1;
                d.sel.lw   = 1'b1;
            end
            OP_SW: begin
                d.sel.aop  = AOP_ADD;
                d.sel.rdts = 1'b1;
                d.sel.rims = 1'b1;
                d.sel.is   = 1'b1;
                d.sel.sw   = 1'b1;
            end
            OP_HALT: begin
                d.legal = 1'b0;
                d.halt  = 1'b1;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    state_t            state_q, state_d;
    sel_t              sel_q;
    dec_t              dec_now;
    logic [TMO_W-1:0]  wait_cnt;
    logic [1:0]        err_q, err_d;
    logic [ICNT_W-1:0] icnt_q;
    logic              load_sel, retire, cnt_clr, cnt_inc;

    assign dec_now = decode(opa, funca);

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            wait_cnt <= '0;
            err_q    <= ERR_NONE;
            icnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (load_sel) sel_q <= dec_now.sel;
            if (cnt_clr)
                wait_cnt <= '0;
            else if (cnt_inc)
                wait_cnt <= wait_cnt + 1'b1;
            if (retire) icnt_q <= icnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        load_sel = 1'b0;
        retire   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run || step) state_d = S_IF;
            end
            S_IF: begin
                pc_we   = 1'b1;
                ir_we   = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                if (dec_now.legal) begin
                    load_sel = 1'b1;
                    state_d  = S_EX;
                end else begin
                    state_d = S_HALT;
                    if (!dec_now.halt) err_d = ERR_ILL;
                end
            end
            S_EX: begin
                cnt_clr = 1'b1;
                state_d = (sel_q.lw || sel_q.sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_re = sel_q.lw;
                mem_we = sel_q.sw;
                // A ready in the final allowed wait cycle still completes the access.
                if (mem_rdy) begin
                    if (sel_q.lw) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = run ? S_IF : S_IDLE;
                    end
                end else if (wait_cnt == TMO_LIM) begin
                    err_d   = ERR_TMO;
                    state_d = S_HALT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = run ? S_IF : S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            S_BAD:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign aop    = sel_q.aop;
    assign rdts   = sel_q.rdts;
    assign is     = sel_q.is;
    assign rims   = sel_q.rims;
    assign ams    = sel_q.ams;
    assign state  = state_q;
    assign halted = (state_q == S_HALT);
    assign err    = err_q;
    assign icnt   = icnt_q;

endmodule
